// File: rtl/mux_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Segment table is active-high, bit order {g,f,e,d,c,b,a}.
package mux_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  localparam int DEF_NUM_DIGITS    = 4;
  localparam int DEF_BLANK_TICKS   = 1;
  localparam int DEF_DRIVE_TICKS   = 4;
  localparam int DEF_ANODE_ACT_LOW = 1;
  localparam int DEF_SEG_ACT_LOW   = 1;

  // Entry 15 first: packed concat puts index 0 at the LSB end.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seven_seg_decoder.sv
// Nibble to hex glyph, with blanking and output polarity applied here.
// Purely combinational; the scanner registers the result.
module seven_seg_decoder
  import mux_display_pkg::*;
#(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  logic [6:0] w_hi;

  assign w_hi  = i_blank ? 7'h00 : SEG_LUT[i_nibble];
  assign o_seg = ACT_LOW ? ~w_hi : w_hi;

endmodule

// File: rtl/mux_display_scanner.sv
// Time-multiplexed 7-segment scanner with blanking dead-time per digit.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module mux_display_scanner
  import mux_display_pkg::*;
#(
  parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
  parameter int BLANK_TICKS   = DEF_BLANK_TICKS,
  parameter int DRIVE_TICKS   = DEF_DRIVE_TICKS,
  parameter int ANODE_ACT_LOW = DEF_ANODE_ACT_LOW,
  parameter int SEG_ACT_LOW   = DEF_SEG_ACT_LOW
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  input  logic                    scan_tick,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   anode_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int MAXT = (BLANK_TICKS > DRIVE_TICKS) ?
                        BLANK_TICKS : DRIVE_TICKS;
  localparam int CW = $clog2(MAXT + 1);
  localparam int IW = (NUM_DIGITS > 1) ?
                      $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    {NUM_DIGITS{(ANODE_ACT_LOW != 0)}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);
  localparam logic [6:0] SEG_OFF = {7{(SEG_ACT_LOW != 0)}};
  localparam logic       DP_OFF  = (SEG_ACT_LOW != 0);

  state_t                       r_state;
  logic [IW-1:0]                r_idx;
  logic [CW-1:0]                r_cnt;
  logic [NUM_DIGITS-1:0][3:0]   r_val;
  logic [NUM_DIGITS-1:0]        r_dp;

  logic                         w_blank;
  logic                         w_dp_bit;
  logic [NUM_DIGITS-1:0]        w_anode;
  logic [6:0]                   w_seg;
  logic                         w_dp;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz;

  // Digit i is a leading zero when it and every higher digit are 0.
  always_comb begin : lz_scan
    logic run;
    run  = 1'b1;
    w_lz = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run     = run & (r_val[i] == 4'h0);
      w_lz[i] = run;
    end
  end

  assign w_blank = w_lz[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  assign w_dp_bit = r_dp[r_idx];
  assign w_dp     = DP_OFF ^ w_dp_bit;
  assign w_anode  = (w_blank && !w_dp_bit) ? AN_OFF :
                    (AN_OFF ^ (AN_ONE << r_idx));

  seven_seg_decoder #(
    .ACT_LOW (SEG_ACT_LOW != 0)
  ) u_dec (
    .i_nibble (r_val[r_idx]),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_val      <= '0;
      r_dp       <= '0;
      anode_out  <= AN_OFF;
      seg_out    <= SEG_OFF;
      dp_out     <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        r_state   <= IDLE;
        r_idx     <= '0;
        r_cnt     <= '0;
        anode_out <= AN_OFF;
        seg_out   <= SEG_OFF;
        dp_out    <= DP_OFF;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state <= BLANK;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_val   <= value_in;
            r_dp    <= dp_in;
          end
          BLANK: begin
            if (scan_tick) begin
              if (r_cnt == BLANK_LAST) begin
                r_state   <= DRIVE;
                r_cnt     <= '0;
                anode_out <= w_anode;
                seg_out   <= w_seg;
                dp_out    <= w_dp;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          DRIVE: begin
            if (scan_tick) begin
              if (r_cnt == DRIVE_LAST) begin
                r_state   <= BLANK;
                r_cnt     <= '0;
                anode_out <= AN_OFF;
                seg_out   <= SEG_OFF;
                dp_out    <= DP_OFF;
                // New frame: value snapshot taken at the wrap.
                if (r_idx == IDX_LAST) begin
                  r_idx      <= '0;
                  frame_done <= 1'b1;
                  r_val      <= value_in;
                  r_dp       <= dp_in;
                end else begin
                  r_idx <= r_idx + 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_display_scanner.sv
// Scoreboard bench for mux_display_scanner: expected snapshots queued
// by stimulus, popped and compared by a negedge monitor.
module tb_mux_display_scanner;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick  = 1'b0;
  logic        en    = 1'b1;
  logic [15:0] val   = 16'h1234;
  logic [3:0]  dpi   = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dpo;
  logic        fd;

  int cyc    = 0;
  int n_run  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  typedef struct {
    int         c;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t q[$];

  mux_display_scanner dut (
    .clock_in   (clk),
    .reset_n    (rst_n),
    .scan_tick  (tick),
    .enable     (en),
    .value_in   (val),
    .dp_in      (dpi),
    .anode_out  (an),
    .seg_out    (seg),
    .dp_out     (dpo),
    .frame_done (fd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      n_run++;
      if (e.c != cyc ||
          {an, seg, dpo, fd} !== {e.an, e.seg, e.dp, e.fd}) begin
        n_fail++;
        $display("FAIL %s: cyc %0d got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b at cyc %0d",
                 e.tag, cyc, an, seg, dpo, fd,
                 e.an, e.seg, e.dp, e.fd, e.c);
      end
    end
    if (done && q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL pending: %0d unchecked entries, got 0 want none",
               q.size());
      q.delete();
    end
  end

  // Active-low glyphs, gfedcba.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  task automatic expect_at(input int c, input logic [3:0] a,
                           input logic [6:0] s, input logic d,
                           input logic f, input string t);
    exp_t e;
    e.c   = c;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    e.fd  = f;
    e.tag = t;
    q.push_back(e);
  endtask

  task automatic slot(input int s, input logic [15:0] v,
                      input logic [3:0] d, output logic [3:0] a,
                      output logic [6:0] sg, output logic dp);
    a    = 4'b1111;
    a[s] = 1'b0;
    sg   = glyph(v[4*s +: 4]);
    dp   = ~d[s];
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0 && (v >> (4*s)) == 16'h0) begin
      sg = 7'h7F;
      if (!d[s]) a = 4'b1111;
    end
`endif
  endtask

  // Issue n ticks, gap idle clocks before each; position k counts
  // from the first tick after a BLANK slot at digit 0.
  task automatic run_ticks(input int n, input int gap,
                           input logic [15:0] v, input logic [3:0] d,
                           input int chg, input logic [15:0] nv,
                           input logic [3:0] nd);
    for (int k = 1; k <= n; k++) begin
      int p;
      int s;
      logic [3:0] a;
      logic [6:0] sg;
      logic       dp;
      repeat (gap) @(negedge clk);
      if (k == chg) begin
        val = nv;
        dpi = nd;
      end
      p = (k - 1) % 20;
      s = p / 5;
      if (p % 5 == 4) begin
        expect_at(cyc + 1, 4'hF, 7'h7F, 1'b1, (s == 3),
                  $sformatf("blank_after_d%0d", s));
        if (gap > 1)
          expect_at(cyc + 2, 4'hF, 7'h7F, 1'b1, 1'b0, "fd_clear");
      end else begin
        slot(s, v, d, a, sg, dp);
        expect_at(cyc + 1, a, sg, dp, 1'b0,
                  $sformatf("drive_d%0d_v%h", s, v));
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 5; k++) begin
      repeat (49) @(negedge clk);
      expect_at(cyc + 1, 4'hF, 7'h7F, 1'b1, 1'b0, "reset_dark");
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b1;

    run_ticks(20, 49, 16'h1234, 4'b0000, 7, 16'hABCD, 4'b0101);
    run_ticks(20, 49, 16'hABCD, 4'b0101, 7, 16'h0050, 4'b1000);
    run_ticks(20, 3, 16'h0050, 4'b1000, 7, 16'h1234, 4'b0000);
    run_ticks(12, 3, 16'h1234, 4'b0000, 0, 16'h0, 4'b0);

    en = 1'b0;
    expect_at(cyc + 1, 4'hF, 7'h7F, 1'b1, 1'b0, "enable_off");
    @(negedge clk);
    expect_at(cyc + 1, 4'hF, 7'h7F, 1'b1, 1'b0, "tick_while_off");
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    val = 16'h5A0F;
    dpi = 4'b0000;
    en  = 1'b1;
    expect_at(cyc + 1, 4'hF, 7'h7F, 1'b1, 1'b0, "reenable_blank");
    @(negedge clk);

    run_ticks(40, 0, 16'h5A0F, 4'b0000, 0, 16'h0, 4'b0);
    run_ticks(3, 0, 16'h5A0F, 4'b0000, 0, 16'h0, 4'b0);

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expect_at(cyc, 4'hF, 7'h7F, 1'b1, 1'b0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: cyc %0d, want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
